// File: rtl/fx_xfade_sel.sv
// Click-free stereo source selector: fades the routed source out to zero, swaps
// to the newly selected source, then fades it back in, one step per VALID strobe.
module fx_xfade_sel #(
  parameter int NUM_SRC   = 4,
  parameter int FADE_BITS = 8,
  localparam int SEL_W    = $clog2(NUM_SRC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   VALID,
  input  logic [SEL_W-1:0]       sel,
  input  logic [16*NUM_SRC-1:0]  fx_left,
  input  logic [16*NUM_SRC-1:0]  fx_right,
  output logic [15:0]            left_out,
  output logic [15:0]            right_out,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       active_sel,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int GW = FADE_BITS + 1;
  localparam int PW = 16 + FADE_BITS + 2;
  localparam logic [GW-1:0] G_FULL = {1'b1, {FADE_BITS{1'b0}}};
  localparam logic [GW-1:0] G_ONE  = GW'(1);

  typedef enum logic [1:0] {PASS = 2'd0, FADE_OUT = 2'd1, FADE_IN = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    g_q, g_d;
  logic [SEL_W-1:0] act_q, act_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [15:0]      left_q, left_d;
  logic [15:0]      right_q, right_d;
  logic             ov_q, ov_d;

  logic [15:0]          src_l, src_r;
  logic signed [PW-1:0] prod_l, prod_r, sh_l, sh_r;

  assign src_l = fx_left[16*int'(act_q) +: 16];
  assign src_r = fx_right[16*int'(act_q) +: 16];

  // Gain is a non-negative fraction of FULL, so it is zero-extended before the signed multiply.
  assign prod_l = $signed({{(PW-16){src_l[15]}}, src_l}) * $signed({{(PW-GW){1'b0}}, g_q});
  assign prod_r = $signed({{(PW-16){src_r[15]}}, src_r}) * $signed({{(PW-GW){1'b0}}, g_q});
  assign sh_l   = prod_l >>> FADE_BITS;
  assign sh_r   = prod_r >>> FADE_BITS;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    act_d   = act_q;
    tgt_d   = tgt_q;
    left_d  = left_q;
    right_d = right_q;
    ov_d    = 1'b0;
    if (VALID) begin
      left_d  = sh_l[15:0];
      right_d = sh_r[15:0];
      ov_d    = 1'b1;
      case (state_q)
        PASS: begin
          if (sel != act_q && int'(sel) < NUM_SRC) begin
            tgt_d   = sel;
            g_d     = G_FULL - G_ONE;
            state_d = FADE_OUT;
          end
        end
        FADE_OUT: begin
          if (g_q == '0) begin
            act_d   = tgt_q;
            g_d     = G_ONE;
            state_d = FADE_IN;
          end else begin
            g_d = g_q - G_ONE;
          end
        end
        FADE_IN: begin
          if (g_q == G_FULL) begin
            state_d = PASS;
          end else begin
            g_d = g_q + G_ONE;
          end
        end
        default: state_d = PASS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PASS;
      g_q     <= G_FULL;
      act_q   <= '0;
      tgt_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      act_q   <= act_d;
      tgt_q   <= tgt_d;
      left_q  <= left_d;
      right_q <= right_d;
      ov_q    <= ov_d;
    end
  end

  assign left_out   = left_q;
  assign right_out  = right_q;
  assign out_valid  = ov_q;
  assign active_sel = act_q;
  assign busy       = (state_q != PASS);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fx_xfade_sel.sv
// Bench for fx_xfade_sel with a short fade (FADE_BITS=2) so whole switches fit in a few samples.
module tb_fx_xfade_sel;
  localparam int NUM_SRC = 4;
  localparam int FB      = 2;
  localparam int FULL    = 1 << FB;
  localparam int SEL_W   = 2;
  localparam int W       = 16 + 16 + SEL_W + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  VALID = 1'b0;
  logic [SEL_W-1:0]      sel = '0;
  logic [16*NUM_SRC-1:0] fx_left = '0;
  logic [16*NUM_SRC-1:0] fx_right = '0;
  logic [15:0]           left_out, right_out;
  logic                  out_valid, busy;
  logic [SEL_W-1:0]      active_sel;
  logic [1:0]            dbg_state;

  fx_xfade_sel #(.NUM_SRC(NUM_SRC), .FADE_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .VALID(VALID), .sel(sel),
    .fx_left(fx_left), .fx_right(fx_right),
    .left_out(left_out), .right_out(right_out), .out_valid(out_valid),
    .active_sel(active_sel), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model state: 0 pass, 1 fade-out, 2 fade-in
  int m_state, m_g, m_act, m_tgt;
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] gain(input logic [15:0] x, input int g);
    int p;
    p = int'($signed(x)) * g;
    return 16'(p >>> FB);
  endfunction

  task automatic model_reset();
    m_state = 0; m_g = FULL; m_act = 0; m_tgt = 0;
  endtask

  task automatic set_src(input int i, input logic [15:0] l, input logic [15:0] r);
    fx_left[16*i +: 16]  = l;
    fx_right[16*i +: 16] = r;
  endtask

  task automatic rand_src();
    for (int i = 0; i < NUM_SRC; i++)
      set_src(i, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
  endtask

  task automatic sample(input logic [SEL_W-1:0] s);
    logic [15:0] el, er;
    logic [W-1:0] e;
    sel   = s;
    VALID = 1'b1;
    el = gain(fx_left[16*m_act +: 16], m_g);
    er = gain(fx_right[16*m_act +: 16], m_g);
    case (m_state)
      0: if (int'(s) != m_act && int'(s) < NUM_SRC) begin m_tgt = int'(s); m_g = FULL - 1; m_state = 1; end
      1: if (m_g == 0) begin m_act = m_tgt; m_g = 1; m_state = 2; end else m_g--;
      default: if (m_g == FULL) m_state = 0; else m_g++;
    endcase
    exp_q.push_back({el, er, SEL_W'(m_act), 1'(m_state != 0)});
    @(posedge clk); #1;
    VALID = 1'b0;
    check("out_valid", out_valid, 1);
    check("state", dbg_state, m_state);
    if (exp_q.size() == 0) check("queue_empty", 0, 1);
    else begin
      e = exp_q.pop_front();
      check("sample", {left_out, right_out, active_sel, busy}, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check("idle_valid", out_valid, 0);
    end
  endtask

  logic [15:0] tp_left [9] = '{16'h4000, 16'h3000, 16'h2000, 16'h1000, 16'h0000,
                               16'h0800, 16'h1000, 16'h1800, 16'h2000};

  initial begin
    logic [W-1:0] held;
    model_reset();

    // Reset with strobes active
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_src();
      sel = SEL_W'($urandom_range(0, 3));
      VALID = 1'b1;
      @(posedge clk); #1;
      check("reset_out", {left_out, right_out, out_valid, busy, active_sel}, 0);
    end
    VALID = 1'b0;
    rst_n = 1'b1;
    idle(1);

    set_src(0, 16'h1234, 16'h4321);
    sample(0);
    check("pass_left", left_out, 16'h1234);
    check("pass_right", right_out, 16'h4321);

    // Switch 0 -> 2, with sel moved to 3 during the fade-out
    set_src(0, 16'h4000, 16'h1111);
    set_src(2, 16'h2000, 16'hE000);
    for (int i = 0; i < 9; i++) begin
      sample((i >= 2) ? 2'd3 : 2'd2);
      check("switch_left", left_out, tp_left[i]);
      if (i >= 4) check("switch_act", active_sel, 2);
      if (i >= 1 && i <= 7) check("switch_busy", busy, 1);
      if (i == 8) check("switch_done", busy, 0);
    end
    sample(3);
    check("redetect_busy", busy, 1);
    check("redetect_act", active_sel, 2);
    repeat (8) sample(3);
    check("switch3_act", active_sel, 3);

    // Sign and truncation on the outgoing source (3 -> 1)
    set_src(3, 16'h8000, 16'h7FFF);
    sample(1);
    check("neg_full", left_out, 16'h8000);
    set_src(3, 16'hFFFF, 16'h0001);
    sample(1);
    check("neg_one_g3", left_out, 16'hFFFF);
    check("pos_one_g3", right_out, 16'h0000);
    set_src(3, 16'h8000, 16'h8000);
    sample(1);
    check("neg_half", left_out, 16'hC000);
    repeat (6) sample(1);

    // Reset during fade-in
    rand_src();
    repeat (6) sample(2);
    check("in_fade_in", dbg_state, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check("midrst_out", {left_out, right_out, out_valid, busy, active_sel}, 0);
    set_src(0, 16'h1357, 16'h9ABC);
    sample(0);
    check("postrst_left", left_out, 16'h1357);
    check("postrst_right", right_out, 16'h9ABC);

    // Inputs wander without strobes
    sample(1);
    held = {left_out, right_out, active_sel, busy};
    repeat (100) begin
      rand_src();
      sel = SEL_W'($urandom_range(0, 3));
      @(posedge clk); #1;
      check("nostrobe_out", {left_out, right_out, active_sel, busy}, held);
      check("nostrobe_valid", out_valid, 0);
    end

    // Random traffic, mostly back-to-back strobes
    repeat (300) begin
      rand_src();
      if ($urandom_range(0, 3) == 0) idle(1);
      if ($urandom_range(0, 9) == 0) sample(SEL_W'($urandom_range(0, 3)));
      else sample(SEL_W'(m_state == 0 ? m_act : $urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fx_xfade_sel.md
# fx_xfade_sel

Click-free effect-source selector between the effect digital cores and `codec_interface`. It takes the left/right outputs of up to NUM_SRC effect cores (dry signal wired in as one source) and a source select from the board switches. It drives the single `left_out`/`right_out` pair fed to the codec. On a select change it fades the current source out linearly to zero over 2^FADE_BITS samples, switches source, then fades the new source in, all paced by the codec `VALID` sample strobe.

## Interface
- NUM_SRC, 4, number of stereo sources (2..8); SEL_W = $clog2(NUM_SRC)
- FADE_BITS, 8, fade length per half = FULL = 2^FADE_BITS samples (1..10)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- VALID  in  1  one-cycle sample strobe from codec_interface; each high cycle counts as one sample
- sel  in  SEL_W  requested source index, sampled only on VALID
- fx_left  in  16*NUM_SRC  signed left samples, source i at [16i+15:16i]
- fx_right  in  16*NUM_SRC  signed right samples, same packing
- left_out  out  16  signed gained left sample, registered
- right_out  out  16  signed gained right sample, registered
- out_valid  out  1  pulses one cycle when left_out/right_out update
- active_sel  out  SEL_W  source currently routed
- busy  out  1  high while a fade is in progress (state != PASS)

## Operation
- States: PASS, FADE_OUT, FADE_IN. Gain register g, unsigned, FADE_BITS+1 bits, range 0..FULL.
- Reset values:
  - state=PASS, g=FULL, active_sel=0
  - left_out=right_out=0, out_valid=0, busy=0
- Nothing changes on cycles without VALID; sel changes between strobes are ignored.
- Each VALID: left_out = (fx_left[active_sel] * g) >>> FADE_BITS; right_out likewise; g and active_sel are the values before this cycle's update.
- Arithmetic rules:
  - g is zero-extended to signed.
  - Product width is 16+FADE_BITS+2.
  - The shift is an arithmetic shift (truncation toward -inf); keep the low 16 bits.
  - No overflow is possible. g=FULL reproduces the input exactly.
- PASS on VALID: if sel != active_sel and sel < NUM_SRC, latch target=sel, set g<=FULL-1, go FADE_OUT. Otherwise stay.
- FADE_OUT on VALID: if g==0, set active_sel<=target, g<=1, go FADE_IN. Otherwise g<=g-1.
- FADE_IN on VALID: if g==FULL, go PASS (g stays FULL). Otherwise g<=g+1.
- A switch is therefore: the detection sample at FULL, FULL fade-out samples (gain FULL-1..0, old source), then FULL fade-in samples (gain 1..FULL, new source).
- sel changes during FADE_OUT/FADE_IN are ignored; target is fixed at detection. The new value is re-evaluated on the first VALID in PASS.
- sel equal to the target or to the old source mid-fade: the fade still completes.
- sel >= NUM_SRC (non-power-of-two NUM_SRC): treated as no change.
- Reset asserted mid-fade: returns to reset values on the next clock edge; any fade in progress is abandoned.

## Timing
- Latency: outputs and out_valid update on the clock edge ending the VALID cycle, i.e. visible the cycle after VALID. out_valid is high exactly one cycle per VALID.
- fx_left/fx_right/sel are sampled only in the VALID cycle and need not be held afterwards.
- busy and active_sel are registered and change at the same edge as the outputs of the sample that caused the transition.
- Back-to-back VALID (every cycle) is legal; every cycle is one sample step.
- Full switch occupies 2*FULL+1 VALID strobes, measured from detection to the first PASS output.

## Test plan
- Reset/pass-through:
  - Stimulus: rst_n low 3 cycles with VALID pulsing.
  - Required during reset: outputs 0, out_valid 0, busy 0, active_sel 0.
  - Then sel=0, fx_left[0]=16'h1234, one VALID. Required next cycle: left_out=16'h1234, out_valid=1.
- Switch with FADE_BITS=2:
  - Stimulus: sel 0->2, src0 left=16'h4000, src2 left=16'h2000.
  - Required left_out per VALID: 4000,3000,2000,1000,0000,0800,1000,1800,2000.
  - active_sel=2 from the 0000 sample onward. busy high from 3000 through 1800, low after the final 2000.
- Sign/truncation:
  - Source 16'hFFFF at g=3 -> FFFF.
  - Source 16'h8000 at g=FULL -> 8000.
  - Source 16'h8000 at g=2 (FADE_BITS=2) -> C000.
- Mid-fade sel change: during FADE_OUT toggle sel to 3. Required: fade completes to source 2. The first PASS VALID then detects 3 and starts a new fade.
- Reset mid-fade: rst_n low one cycle during FADE_IN. Required next cycle: busy 0, active_sel 0, outputs 0. Next VALID passes source 0 at full gain.
- No strobe: change sel and fx inputs for 100 cycles with VALID low. Required: all outputs unchanged, out_valid 0.
